// File: rtl/xor_pkg.sv
// Shared word width, count width, default accumulator width and the state type
// used by the XOR popcount accumulator.
package xor_pkg;

    localparam int WORD_W    = 16;
    localparam int CNT_W     = 5;
    localparam int ACC_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/popcount16.sv
// Combinational population count of one 16-bit mismatch word.
module popcount16
    import xor_pkg::*;
(
    input  logic [WORD_W-1:0] data_i,
    output logic [CNT_W-1:0]  count_o
);

    // Sum the set bits of the word.
    always_comb begin
        count_o = {CNT_W{1'b0}};
        for (int i = 0; i < WORD_W; i++) begin
            count_o = count_o + CNT_W'(data_i[i]);
        end
    end

endmodule

// File: rtl/xor_popcount_acc.sv
// Accumulates mismatch popcounts over a multi-beat vector and presents the
// binarized dot product (bits - 2*mismatches) with saturation and handshake.
module xor_popcount_acc
    import xor_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_W-1:0]       in_xor,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W:0]   out_dot,
    output logic [ACC_W-1:0]        out_bits,
    output logic                    out_ovf
);

    localparam logic [ACC_W-1:0] ACC_MAX   = {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] WORD_BITS = ACC_W'(WORD_W);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   pc_s, pc_q, pc_d;
    logic               s1_valid_q, s1_valid_d;
    logic [ACC_W-1:0]   mism_q, mism_d;
    logic [ACC_W-1:0]   bits_q, bits_d;
    logic               ovf_q, ovf_d;
    logic               accept_s;
    logic               hold_s;
    logic [ACC_W:0]     mism_sum_s;
    logic [ACC_W:0]     bits_sum_s;
    logic [ACC_W:0]     dot_s;

    // Returns {saturated, value}; clamps to all-ones on carry out.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[ACC_W]) begin
            sat_add = {1'b1, ACC_MAX};
        end else begin
            sat_add = sum;
        end
    endfunction

    popcount16 u_popcount (
        .data_i  (in_xor),
        .count_o (pc_s)
    );

    assign in_ready   = (state_q == ST_ACC);
    assign hold_s     = (state_q == ST_HOLD);
    assign out_valid  = hold_s;
    assign accept_s   = in_valid && in_ready;
    assign mism_sum_s = sat_add(mism_q, ACC_W'(pc_q));
    assign bits_sum_s = sat_add(bits_q, WORD_BITS);

    // Modular subtraction is exact here: the result always fits ACC_W+1 signed bits.
    assign dot_s    = {1'b0, bits_q} - {mism_q, 1'b0};
    assign out_dot  = hold_s ? dot_s  : {(ACC_W+1){1'b0}};
    assign out_bits = hold_s ? bits_q : {ACC_W{1'b0}};
    assign out_ovf  = hold_s ? ovf_q  : 1'b0;

    // Next-state: stage-1 capture, saturating accumulation and the ACC/FLUSH/HOLD flow.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        s1_valid_d = accept_s;
        mism_d     = mism_q;
        bits_d     = bits_q;
        ovf_d      = ovf_q;

        if (accept_s) begin
            pc_d = pc_s;
        end else begin
            pc_d = pc_q;
        end

        if (s1_valid_q) begin
            mism_d = mism_sum_s[ACC_W-1:0];
            bits_d = bits_sum_s[ACC_W-1:0];
            ovf_d  = ovf_q | mism_sum_s[ACC_W] | bits_sum_s[ACC_W];
        end else begin
            mism_d = mism_q;
            bits_d = bits_q;
            ovf_d  = ovf_q;
        end

        case (state_q)
            ST_ACC: begin
                if (accept_s && in_last) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_FLUSH: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // Stage 1 is empty in HOLD, so the clear cannot collide with an add.
                if (out_ready) begin
                    state_d = ST_ACC;
                    mism_d  = {ACC_W{1'b0}};
                    bits_d  = {ACC_W{1'b0}};
                    ovf_d   = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // State, stage-1 and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ACC;
            pc_q       <= {CNT_W{1'b0}};
            s1_valid_q <= 1'b0;
            mism_q     <= {ACC_W{1'b0}};
            bits_q     <= {ACC_W{1'b0}};
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            s1_valid_q <= s1_valid_d;
            mism_q     <= mism_d;
            bits_q     <= bits_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_xor_popcount_acc.sv
// Self-checking bench for xor_popcount_acc: directed table, corner sequences,
// randomized vectors against a popcount/saturation model, and an 8-bit instance.
module tb_xor_popcount_acc;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready, in_last;
    logic [15:0]        in_xor;
    logic               out_valid, out_ready, out_ovf;
    logic signed [16:0] out_dot;
    logic [15:0]        out_bits;

    logic               in_valid8, in_ready8, in_last8;
    logic [15:0]        in_xor8;
    logic               out_valid8, out_ready8, out_ovf8;
    logic signed [8:0]  out_dot8;
    logic [7:0]         out_bits8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    xor_popcount_acc #(.ACC_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_xor(in_xor), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_dot(out_dot), .out_bits(out_bits),
        .out_ovf(out_ovf)
    );

    xor_popcount_acc #(.ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_xor(in_xor8), .in_last(in_last8), .out_valid(out_valid8),
        .out_ready(out_ready8), .out_dot(out_dot8), .out_bits(out_bits8),
        .out_ovf(out_ovf8)
    );

    typedef struct {
        logic [15:0] w [4];
        int          n;
        int          e_dot;
        int          e_bits;
        int          e_ovf;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: total bits and total mismatches, each clamped at 2^accw-1.
    task automatic model(input logic [15:0] ws[$], input int accw,
                         output int e_dot, output int e_bits, output int e_ovf);
        int mx, b, m;
        mx = (1 << accw) - 1;
        b  = 16 * ws.size();
        m  = 0;
        foreach (ws[i]) m += $countones(ws[i]);
        e_ovf  = (b > mx || m > mx) ? 1 : 0;
        if (b > mx) b = mx;
        if (m > mx) m = mx;
        e_bits = b;
        e_dot  = b - 2 * m;
    endtask

    task automatic send_beat(input logic [15:0] w, input logic last);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_xor   = w;
        in_last  = last;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (in_ready) ok = 1'b1;
            tick();
        end
        if (!ok) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_xor   = 16'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic run_vector(input string tag, input logic [15:0] ws[$],
                              input int gap_max, input int hold_cyc,
                              input int e_dot, input int e_bits, input int e_ovf);
        for (int i = 0; i < ws.size(); i++) begin
            int gap;
            gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (gap) tick();
            send_beat(ws[i], (i == ws.size() - 1) ? 1'b1 : 1'b0);
        end
        check({tag, ":valid_early"}, int'(out_valid), 0);
        tick();
        check({tag, ":valid"}, int'(out_valid), 1);
        check({tag, ":dot"},   int'(out_dot),   e_dot);
        check({tag, ":bits"},  int'(out_bits),  e_bits);
        check({tag, ":ovf"},   int'(out_ovf),   e_ovf);
        for (int c = 0; c < hold_cyc; c++) begin
            in_valid = 1'b1;
            in_xor   = 16'($urandom);
            in_last  = 1'($urandom);
            tick();
            check({tag, ":hold_ready"}, int'(in_ready),  0);
            check({tag, ":hold_valid"}, int'(out_valid), 1);
            check({tag, ":hold_dot"},   int'(out_dot),   e_dot);
            check({tag, ":hold_bits"},  int'(out_bits),  e_bits);
            check({tag, ":hold_ovf"},   int'(out_ovf),   e_ovf);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, ":post_valid"}, int'(out_valid), 0);
        check({tag, ":post_ready"}, int'(in_ready),  1);
        check({tag, ":post_dot"},   int'(out_dot),   0);
        check({tag, ":post_bits"},  int'(out_bits),  0);
        check({tag, ":post_ovf"},   int'(out_ovf),   0);
    endtask

    initial begin
        logic [15:0] ws[$];
        int ed, eb, eo;

        tbl[0] = '{w: '{16'h0000, 16'h0000, 16'h0000, 16'h0000}, n: 1, e_dot: 16,  e_bits: 16, e_ovf: 0};
        tbl[1] = '{w: '{16'h0157, 16'hFFFF, 16'h0000, 16'h0000}, n: 2, e_dot: -12, e_bits: 32, e_ovf: 0};
        tbl[2] = '{w: '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000}, n: 1, e_dot: -16, e_bits: 16, e_ovf: 0};
        tbl[3] = '{w: '{16'h00FF, 16'h0F0F, 16'hAAAA, 16'h8001}, n: 4, e_dot: 12,  e_bits: 64, e_ovf: 0};
        tbl[4] = '{w: '{16'h0001, 16'h0000, 16'h0000, 16'h0000}, n: 3, e_dot: 46,  e_bits: 48, e_ovf: 0};

        rst = 1'b1;
        in_valid = 1'b0; in_xor = 16'h0000; in_last = 1'b0; out_ready = 1'b0;
        in_valid8 = 1'b0; in_xor8 = 16'h0000; in_last8 = 1'b0; out_ready8 = 1'b0;
        repeat (3) tick();
        check("rst:ready", int'(in_ready),  1);
        check("rst:valid", int'(out_valid), 0);
        rst = 1'b0;
        tick();
        check("rel:ready", int'(in_ready),  1);
        check("rel:valid", int'(out_valid), 0);
        check("rel:dot",   int'(out_dot),   0);
        check("rel:bits",  int'(out_bits),  0);
        check("rel:ovf",   int'(out_ovf),   0);

        for (int t = 0; t < 5; t++) begin
            ws = {};
            for (int i = 0; i < tbl[t].n; i++) ws.push_back(tbl[t].w[i]);
            run_vector($sformatf("tbl%0d", t), ws, 0, 0, tbl[t].e_dot, tbl[t].e_bits, tbl[t].e_ovf);
        end

        // Back-pressure with upstream traffic, then a fresh vector.
        ws = {16'h0157, 16'hFFFF};
        run_vector("bp", ws, 0, 5, -12, 32, 0);
        ws = {16'h0000};
        run_vector("bp_next", ws, 0, 0, 16, 16, 0);

        // Reset in the middle of a vector discards the partial sums.
        send_beat(16'hFFFF, 1'b0);
        send_beat(16'hFFFF, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst:ready", int'(in_ready),  1);
        check("midrst:valid", int'(out_valid), 0);
        check("midrst:dot",   int'(out_dot),   0);
        check("midrst:bits",  int'(out_bits),  0);
        check("midrst:ovf",   int'(out_ovf),   0);
        tick();
        rst = 1'b0;
        tick();
        ws = {16'h00FF};
        run_vector("after_rst", ws, 0, 0, 0, 16, 0);

        for (int r = 0; r < 40; r++) begin
            int len;
            len = int'($urandom_range(1, 6));
            ws = {};
            for (int i = 0; i < len; i++) ws.push_back(16'($urandom));
            model(ws, 16, ed, eb, eo);
            run_vector($sformatf("rnd%0d", r), ws, 2, int'($urandom_range(0, 3)), ed, eb, eo);
        end

        // 8-bit accumulator saturates after 16 all-mismatch beats.
        for (int i = 0; i < 16; i++) begin
            in_valid8 = 1'b1;
            in_xor8   = 16'hFFFF;
            in_last8  = (i == 15) ? 1'b1 : 1'b0;
            if (i == 0) check("w8:ready", int'(in_ready8), 1);
            tick();
        end
        in_valid8 = 1'b0;
        check("w8:valid_early", int'(out_valid8), 0);
        tick();
        ws = {};
        repeat (16) ws.push_back(16'hFFFF);
        model(ws, 8, ed, eb, eo);
        check("w8:valid", int'(out_valid8), 1);
        check("w8:bits",  int'(out_bits8),  255);
        check("w8:dot",   int'(out_dot8),   -255);
        check("w8:ovf",   int'(out_ovf8),   1);
        check("w8:model_dot", int'(out_dot8), ed);
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        check("w8:post_valid", int'(out_valid8), 0);
        in_valid8 = 1'b1; in_xor8 = 16'h0000; in_last8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        tick();
        check("w8b:valid", int'(out_valid8), 1);
        check("w8b:dot",   int'(out_dot8),   16);
        check("w8b:bits",  int'(out_bits8),  16);
        check("w8b:ovf",   int'(out_ovf8),   0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
